arm_alu: RTL and testbench
==========================

# arm_alu

Registered 32-bit ARMv7 data-processing ALU with an integrated barrel shifter on operand B. It executes all sixteen ARM data-processing opcodes and produces the result plus N/Z/C/V flags one clock after the operands are presented. It sits in the execute stage between the register-read/shifter-operand decode and writeback/CPSR update. Write-enable and flag-update decisions (S bit, TST/CMP not writing Rd) are made outside this block.

## Interface
- No parameters; datapath fixed at 32 bits.
- CP  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising CP.
- a  input  32  first operand (Rn).
- b  input  32  second operand before shifting (Rm or immediate).
- op  input  4  ARM opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, 10 CMP, 11 CMN, 12 ORR, 13 MOV, 14 BIC, 15 MVN.
- cin  input  1  current CPSR C flag.
- shift_op  input  3  [2:1] type: 00 LSL, 01 LSR, 10 ASR, 11 ROR; [0] 1 = register-specified amount, 0 = immediate amount.
- shift_num  input  8  shift amount.
- out  output  32  registered result.
- nout, zout, cout, vout  output  1 each  registered N, Z, C, V flags.

## Operation
- Shifter produces s (32 bits) and shifter carry sc from b.
- Immediate mode (shift_op[0]=0): amount = shift_num[4:0], shift_num[7:5] ignored. LSL #0: s=b, sc=cin. LSR #0 and ASR #0 mean shift by 32. ROR #0 means RRX (see Configuration).
- Register mode (shift_op[0]=1): amount = full shift_num[7:0]. Amount 0: s=b, sc=cin for every type.
  - LSL: 1–31 normal, sc = last bit shifted out. 32 gives s=0, sc=b[0]. Above 32 gives s=0, sc=0.
  - LSR: 1–31 normal. 32 gives s=0, sc=b[31]. Above 32 gives s=0, sc=0.
  - ASR: 1–31 normal. 32 or more gives s = 32 copies of b[31], sc=b[31].
  - ROR: amount[4:0]=0 with amount≠0 gives s=b, sc=b[31]. Otherwise rotate right by amount[4:0], sc=s[31].
- Arithmetic; all sums formed 33 bits wide:
  - SUB/CMP: a + ~s + 1.
  - RSB: s + ~a + 1.
  - ADD/CMN: a + s.
  - ADC: a + s + cin.
  - SBC: a + ~s + cin.
  - RSC: s + ~a + cin.
  - C = bit 32 of the sum, so for subtracts C = NOT borrow.
  - V = signed overflow (the two addends have equal sign and the result sign differs).
- Logical:
  - AND/TST: a&s. EOR/TEQ: a^s. ORR: a|s. MOV: s. BIC: a&~s. MVN: ~s.
  - C = sc. V = previous vout (held).
- All ops: N = result[31]; Z = (result==0).
- out is always the computed result, including for TST/TEQ/CMP/CMN.

## Timing
- Combinational shift and compute; single register stage. Latency is 1 cycle: inputs stable before rising CP appear on out and flags after that edge.
- New operation accepted every cycle; no handshake.
- Reset: while reset=0 at a rising edge, out=0, nout=0, zout=0, cout=0, vout=0, overriding any op. The first valid result appears on the first edge with reset=1.
- Reset asserted mid-stream discards the operation sampled at that edge.

## Configuration
- ALU_RRX_EN defined: immediate ROR #0 performs RRX, giving s={cin,b[31:1]} and sc=b[0].
- ALU_RRX_EN undefined: immediate ROR #0 passes b unshifted with sc=cin, same as LSL #0. All other behaviour is identical.

## Test plan
- Reset hold: reset=0 with op=4, a=5, b=3 → after edge out=0 and all flags 0. After release, next edge gives out=8, flags 0.
- ADD, no shift: op=4, a=0xFFFFFFFF, b=1, shift_op=0, shift_num=0 → out=0, Z=1, C=1, N=0, V=0.
- SUB borrow: op=2, a=0, b=1, no shift → out=0xFFFFFFFF, N=1, C=0, Z=0, V=0.
- ADC overflow: op=5, a=0x7FFFFFFF, b=0, cin=1 → out=0x80000000, N=1, V=1, C=0.
- Register shifts via MOV (op=13):
  - b=1, LSL reg 33 (shift_op=1, shift_num=33) → out=0, C=0, Z=1.
  - b=0x80000000, ASR reg 40 (shift_op=5, shift_num=40) → out=0xFFFFFFFF, C=1, N=1.
- Immediate specials via MOV:
  - b=0x80000000, LSR #0 (shift_op=2) → out=0, C=1.
  - With ALU_RRX_EN: b=3, cin=1, ROR #0 (shift_op=6) → out=0x80000001, C=1.
  - Check V held across a logical op that follows the ADC overflow case.

Source files
------------

// File: rtl/arm_alu.sv
// Registered 32-bit ARM data-processing ALU with barrel shifter on operand B.
// Optional macro ALU_RRX_EN: immediate ROR #0 performs RRX instead of passing b through.
module arm_alu (
  input  logic        CP,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  input  logic        cin,
  input  logic [2:0]  shift_op,
  input  logic [7:0]  shift_num,
  output logic [31:0] out,
  output logic        nout,
  output logic        zout,
  output logic        cout,
  output logic        vout
);

  typedef enum logic [3:0] {
    OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
    OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
    OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
    OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
  } alu_op_e;

  logic [7:0]         amt;
  logic [31:0]        s;
  logic               sc;
  logic [32:0]        lsl_t, lsr_t;
  logic signed [32:0] asr_t;
  logic [63:0]        ror_t;

  // Shifter: each shift type carries an extra bit to capture the last bit shifted out.
  always_comb begin
    amt   = shift_op[0] ? shift_num : {3'b000, shift_num[4:0]};
    s     = b;
    sc    = cin;
    lsl_t = {1'b0, b} << amt[4:0];
    lsr_t = {b, 1'b0} >> amt[4:0];
    asr_t = $signed({b, 1'b0}) >>> amt[4:0];
    ror_t = {b, b} >> amt[4:0];
    if (!shift_op[0] && amt == 8'd0) begin
      // Immediate #0 encodings reinterpret LSR/ASR as 32 and ROR as RRX.
      case (shift_op[2:1])
        2'b01: begin s = '0; sc = b[31]; end
        2'b10: begin s = {32{b[31]}}; sc = b[31]; end
`ifdef ALU_RRX_EN
        2'b11: begin s = {cin, b[31:1]}; sc = b[0]; end
`endif
        default: ;
      endcase
    end else if (amt != 8'd0) begin
      case (shift_op[2:1])
        2'b00: begin
          if (amt[7:5] == 3'd0)  begin s = lsl_t[31:0]; sc = lsl_t[32]; end
          else if (amt == 8'd32) begin s = '0; sc = b[0]; end
          else                   begin s = '0; sc = 1'b0; end
        end
        2'b01: begin
          if (amt[7:5] == 3'd0)  begin s = lsr_t[32:1]; sc = lsr_t[0]; end
          else if (amt == 8'd32) begin s = '0; sc = b[31]; end
          else                   begin s = '0; sc = 1'b0; end
        end
        2'b10: begin
          if (amt[7:5] == 3'd0) begin s = asr_t[32:1]; sc = asr_t[0]; end
          else                  begin s = {32{b[31]}}; sc = b[31]; end
        end
        default: begin
          if (amt[4:0] == 5'd0) begin s = b; sc = b[31]; end
          else                  begin s = ror_t[31:0]; sc = ror_t[31]; end
        end
      endcase
    end
  end

  logic [31:0] x, y, res;
  logic        ci, arith;
  logic [32:0] sum;
  logic        c_nx, v_nx;

  always_comb begin
    x     = a;
    y     = s;
    ci    = 1'b0;
    arith = 1'b1;
    res   = '0;
    case (alu_op_e'(op))
      OP_SUB, OP_CMP: begin y = ~s; ci = 1'b1; end
      OP_RSB:         begin x = s; y = ~a; ci = 1'b1; end
      OP_ADD, OP_CMN: ;
      OP_ADC:         ci = cin;
      OP_SBC:         begin y = ~s; ci = cin; end
      OP_RSC:         begin x = s; y = ~a; ci = cin; end
      OP_AND, OP_TST: begin arith = 1'b0; res = a & s; end
      OP_EOR, OP_TEQ: begin arith = 1'b0; res = a ^ s; end
      OP_ORR:         begin arith = 1'b0; res = a | s; end
      OP_MOV:         begin arith = 1'b0; res = s; end
      OP_BIC:         begin arith = 1'b0; res = a & ~s; end
      default:        begin arith = 1'b0; res = ~s; end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    if (arith) begin
      res  = sum[31:0];
      c_nx = sum[32];
      v_nx = (x[31] == y[31]) && (sum[31] != x[31]);
    end else begin
      c_nx = sc;
      v_nx = vout;
    end
  end

  always_ff @(posedge CP) begin
    if (!reset) begin
      out  <= '0;
      nout <= 1'b0;
      zout <= 1'b0;
      cout <= 1'b0;
      vout <= 1'b0;
    end else begin
      out  <= res;
      nout <= res[31];
      zout <= (res == 32'd0);
      cout <= c_nx;
      vout <= v_nx;
    end
  end

endmodule

// File: tb/tb_arm_alu.sv
// Self-checking bench for arm_alu: directed cases then random ops against a behavioural model.
module tb_arm_alu;
  logic        CP = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        cin;
  logic [2:0]  shift_op;
  logic [7:0]  shift_num;
  logic [31:0] out;
  logic        nout, zout, cout, vout;

  int n_cmp = 0;
  int n_bad = 0;
  logic m_v = 1'b0;

  arm_alu dut (
    .CP(CP), .reset(reset), .a(a), .b(b), .op(op), .cin(cin),
    .shift_op(shift_op), .shift_num(shift_num),
    .out(out), .nout(nout), .zout(zout), .cout(cout), .vout(vout)
  );

  always #5 CP = ~CP;

  task automatic model(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop,
                       input logic ic, input logic [2:0] sop, input logic [7:0] snum,
                       input logic vprev, output logic [31:0] r, output logic c, output logic v);
    logic [31:0] s, x, y;
    logic        sc, ci, arith;
    logic [63:0] t, u;
    longint      st, tot;
    int          amt, n;
    amt = sop[0] ? int'(snum) : int'(snum[4:0]);
    s = ib; sc = ic;
    if (!sop[0] && amt == 0) begin
      case (sop[2:1])
        2'd1: begin s = 0; sc = ib[31]; end
        2'd2: begin s = {32{ib[31]}}; sc = ib[31]; end
        2'd3: begin
`ifdef ALU_RRX_EN
          s = {ic, ib[31:1]}; sc = ib[0];
`endif
        end
        default: ;
      endcase
    end else if (amt != 0) begin
      case (sop[2:1])
        2'd0: begin t = {32'd0, ib} << amt; s = t[31:0]; sc = t[32]; end
        2'd1: begin t = {ib, 32'd0} >> amt; s = t[63:32]; sc = t[31]; end
        2'd2: begin st = $signed({ib, 32'd0}); st = st >>> amt; t = st; s = t[63:32]; sc = t[31]; end
        default: begin
          n = amt % 32;
          if (n == 0) begin s = ib; sc = ib[31]; end
          else begin s = (ib >> n) | (ib << (32 - n)); sc = s[31]; end
        end
      endcase
    end
    arith = 1'b1; x = ia; y = s; ci = 1'b0; r = 0;
    case (iop)
      4'd2, 4'd10: begin y = ~s; ci = 1'b1; end
      4'd3:        begin x = s; y = ~ia; ci = 1'b1; end
      4'd4, 4'd11: ;
      4'd5:        ci = ic;
      4'd6:        begin y = ~s; ci = ic; end
      4'd7:        begin x = s; y = ~ia; ci = ic; end
      4'd0, 4'd8:  begin arith = 0; r = ia & s; end
      4'd1, 4'd9:  begin arith = 0; r = ia ^ s; end
      4'd12:       begin arith = 0; r = ia | s; end
      4'd13:       begin arith = 0; r = s; end
      4'd14:       begin arith = 0; r = ia & ~s; end
      default:     begin arith = 0; r = ~s; end
    endcase
    if (arith) begin
      u = 64'(x) + 64'(y) + 64'(ci);
      r = u[31:0];
      c = u[32];
      tot = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      v = (tot != longint'($signed(r)));
    end else begin
      c = sc;
      v = vprev;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [3:0] iop,
                      input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                      input logic [2:0] sop, input logic [7:0] snum);
    logic [31:0] er;
    logic ec, ev;
    reset = rst; op = iop; a = ia; b = ib; cin = ic; shift_op = sop; shift_num = snum;
    if (!rst) begin er = 0; ec = 0; ev = 0; end
    else model(ia, ib, iop, ic, sop, snum, m_v, er, ec, ev);
    @(posedge CP);
    #1;
    m_v = ev;
    chk({tag, ".out"}, out, er);
    chk({tag, ".n"}, {31'd0, nout}, {31'd0, rst & er[31]});
    chk({tag, ".z"}, {31'd0, zout}, {31'd0, rst & (er == 0)});
    chk({tag, ".c"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, ".v"}, {31'd0, vout}, {31'd0, ev});
  endtask

  logic [7:0] sn;

  initial begin
    reset = 1'b0; op = 0; a = 0; b = 0; cin = 0; shift_op = 0; shift_num = 0;
    step("rst_hold", 1'b0, 4'd4, 32'd5, 32'd3, 1'b0, 3'd0, 8'd0);
    chk("rst_out_zero", out, 32'd0);
    step("rst_rel",  1'b1, 4'd4, 32'd5, 32'd3, 1'b0, 3'd0, 8'd0);
    chk("rst_rel_8", out, 32'd8);
    step("add_wrap", 1'b1, 4'd4, 32'hFFFFFFFF, 32'd1, 1'b0, 3'd0, 8'd0);
    step("sub_brw",  1'b1, 4'd2, 32'd0, 32'd1, 1'b0, 3'd0, 8'd0);
    chk("sub_brw_val", out, 32'hFFFFFFFF);
    step("adc_ovf",  1'b1, 4'd5, 32'h7FFFFFFF, 32'd0, 1'b1, 3'd0, 8'd0);
    chk("adc_ovf_v", {31'd0, vout}, 32'd1);
    step("v_hold",   1'b1, 4'd13, 32'd0, 32'h12345678, 1'b0, 3'd0, 8'd4);
    chk("v_hold_v", {31'd0, vout}, 32'd1);
    step("lsl_r33",  1'b1, 4'd13, 32'd0, 32'd1, 1'b0, 3'd1, 8'd33);
    step("lsl_r32",  1'b1, 4'd13, 32'd0, 32'd1, 1'b0, 3'd1, 8'd32);
    step("asr_r40",  1'b1, 4'd13, 32'd0, 32'h80000000, 1'b0, 3'd5, 8'd40);
    chk("asr_r40_val", out, 32'hFFFFFFFF);
    step("lsr_i0",   1'b1, 4'd13, 32'd0, 32'h80000000, 1'b0, 3'd2, 8'd0);
    step("lsr_r32",  1'b1, 4'd13, 32'd0, 32'h80000001, 1'b0, 3'd3, 8'd32);
    step("asr_i0",   1'b1, 4'd13, 32'd0, 32'h80000000, 1'b0, 3'd4, 8'd0);
    step("ror_i0",   1'b1, 4'd13, 32'd0, 32'd3, 1'b1, 3'd6, 8'd0);
    step("ror_r32",  1'b1, 4'd13, 32'd0, 32'h80000003, 1'b0, 3'd7, 8'd64);
    step("ror_r0",   1'b1, 4'd13, 32'd0, 32'h80000003, 1'b1, 3'd7, 8'd0);
    step("lsl_i5h",  1'b1, 4'd13, 32'd0, 32'hF0000001, 1'b0, 3'd0, 8'hE5);
    step("rst_mid",  1'b0, 4'd4, 32'd7, 32'd9, 1'b1, 3'd0, 8'd0);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: sn = 8'd0;
        1: sn = 8'd32;
        2: sn = 8'($urandom_range(1, 31));
        3: sn = 8'($urandom_range(33, 255));
        4: sn = 8'($urandom_range(0, 1)) * 8'd64 + 8'd32;
        default: sn = 8'($urandom);
      endcase
      step("rand", ($urandom_range(0, 24) != 0), 4'($urandom), $urandom,
           ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom,
           1'($urandom), 3'($urandom), sn);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
